// File: rtl/chnl_pkg.sv
// rtl/chnl_pkg.sv - shared state encoding and sizing helpers for the CHNL receiver
//
// Purpose: the receive-channel state encoding, the default buffer depth, and a
// words-per-beat helper. The CHNL receiver and its buffers import this package.
// Ports: none (package).

package chnl_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RECV     = 2'd1,
    S_WAIT_LOW = 2'd2
  } chnl_state_e;

  localparam int FIFO_DEPTH = 16;

  // Number of 32-bit words carried by one RIFFA data beat.
  function automatic int words_per_beat(input int pci_width);
    return pci_width / 32;
  endfunction

endpackage

// File: rtl/fifo.sv
// rtl/fifo.sv - synchronous first-word-fall-through FIFO with valid/ready ports
//
// Purpose: stores WIDTH-bit words. Push and pop are allowed in the same cycle.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_data/in_val/in_rdy     write side; a word is written when in_val && in_rdy
//   out_data/out_val/out_rdy  read side; out_data shows the head word while out_val is high

module fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_val,
  output logic             in_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic             out_val,
  input  logic             out_rdy
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;

  assign in_rdy   = (count != (AW+1)'(DEPTH));
  assign out_val  = (count != '0);
  assign out_data = mem[rd_ptr];
  assign push     = in_val && in_rdy;
  assign pop      = out_val && out_rdy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The storage array is not reset. Only the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: rtl/repacker.sv
// rtl/repacker.sv - width converter from IN units to OUT units of W bits each
//
// Purpose: accepts IN*W-bit words and emits OUT*W-bit words. Units keep their
// order: the lowest unit of a word is the earliest one.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_data/in_val/in_rdy     input side (IN*W bits)
//   out_data/out_val/out_rdy  output side (OUT*W bits), registered

module repacker #(
  parameter int IN  = 1,
  parameter int OUT = 1,
  parameter int W   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [IN*W-1:0] in_data,
  input  logic            in_val,
  output logic            in_rdy,
  output logic [OUT*W-1:0] out_data,
  output logic            out_val,
  input  logic            out_rdy
);

  localparam int CAP = IN + OUT;
  localparam int CW  = $clog2(CAP + 1);

  logic [W-1:0]  units   [CAP];
  logic [W-1:0]  n_units [CAP];
  logic [CW-1:0] cnt;
  logic [CW-1:0] n_cnt;
  logic          pop;
  logic          push;

  assign out_val = (cnt >= CW'(OUT));
  assign pop     = out_val && out_rdy;
  // Ready counts the space that a same-cycle pop frees, so that a matched
  // stream runs at one word per cycle.
  assign in_rdy  = (int'(cnt) - (pop ? OUT : 0) + IN) <= CAP;
  assign push    = in_val && in_rdy;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < OUT; i++) out_data[i*W +: W] = units[i];
  end

  always_comb begin
    int base;
    n_units = units;
    base    = int'(cnt);
    if (pop) begin
      for (int i = 0; i < CAP - OUT; i++) n_units[i] = units[i+OUT];
      for (int i = CAP - OUT; i < CAP; i++) n_units[i] = '0;
      base = base - OUT;
    end
    if (push) begin
      for (int i = 0; i < CAP; i++)
        for (int j = 0; j < IN; j++)
          if (i == base + j) n_units[i] = in_data[j*W +: W];
      base = base + IN;
    end
    n_cnt = CW'(base);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt <= '0;
    else     cnt <= n_cnt;
  end

  always_ff @(posedge clk) begin
    units <= n_units;
  end

endmodule

// File: rtl/chnl_rx.sv
// rtl/chnl_rx.sv - buffered RIFFA CHNL receiver with width repacking
//
// Purpose: accepts one host-to-FPGA RIFFA transaction at a time and buffers its
// beats in a FIFO. It repacks them to RX_WIDTH and presents them on a
// valid/ready stream.
// Optional build macro CHNL_RX_ALIGN_EN: when defined, only whole CHNL_ALIGN
// word groups are forwarded. The trailing beats are still read from the host
// and then dropped.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   o_val/o_rdy/o_data       output stream (RX_WIDTH bits)
//   rx_busy                  a transaction is open
//   CHNL_RX_CLK              copy of clk for the RIFFA channel
//   CHNL_RX/CHNL_RX_ACK      transaction request / one-cycle acknowledge
//   CHNL_RX_LAST/CHNL_RX_OFF unused
//   CHNL_RX_LEN              transaction length in 32-bit words
//   CHNL_RX_DATA/_VALID/_REN host data beat handshake

import chnl_pkg::*;

module chnl_rx #(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int RX_WIDTH         = 32,
  parameter int GCD              = 32,
  parameter int CHNL_ALIGN       = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        o_val,
  input  logic                        o_rdy,
  output logic [RX_WIDTH-1:0]         o_data,
  output logic                        rx_busy,
  output logic                        CHNL_RX_CLK,
  input  logic                        CHNL_RX,
  output logic                        CHNL_RX_ACK,
  input  logic                        CHNL_RX_LAST,
  input  logic [31:0]                 CHNL_RX_LEN,
  input  logic [30:0]                 CHNL_RX_OFF,
  input  logic [C_PCI_DATA_WIDTH-1:0] CHNL_RX_DATA,
  input  logic                        CHNL_RX_DATA_VALID,
  output logic                        CHNL_RX_DATA_REN
);

  localparam int W = words_per_beat(C_PCI_DATA_WIDTH);

  chnl_state_e                 state;
  logic [31:0]                 cnt_left;
  logic [31:0]                 beats_req;
  logic                        accept;
  logic                        push;
  logic                        fifo_in_rdy;
  logic                        fifo_out_val;
  logic                        fifo_out_rdy;
  logic [C_PCI_DATA_WIDTH-1:0] fifo_out_data;
  logic                        unused_ok;

  assign beats_req   = (CHNL_RX_LEN + 32'(W - 1)) / 32'(W);
  assign CHNL_RX_CLK = clk;
  assign CHNL_RX_ACK = (state == S_IDLE) && CHNL_RX;
  assign rx_busy     = (state != S_IDLE);
  assign accept      = CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID;

`ifdef CHNL_RX_ALIGN_EN
  logic [31:0] keep_left;
  logic [31:0] keep_req;

  assign keep_req = ((CHNL_RX_LEN / 32'(CHNL_ALIGN)) * 32'(CHNL_ALIGN)) / 32'(W);
  // Beats past the kept count are discarded, so buffer space does not matter for them.
  assign CHNL_RX_DATA_REN = (state == S_RECV) && ((keep_left == '0) || fifo_in_rdy);
  assign push             = accept && (keep_left != '0);
  assign unused_ok        = ^{CHNL_RX_LAST, CHNL_RX_OFF};
`else
  assign CHNL_RX_DATA_REN = (state == S_RECV) && fifo_in_rdy;
  assign push             = accept;
  assign unused_ok        = ^{CHNL_RX_LAST, CHNL_RX_OFF, 32'(CHNL_ALIGN)};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt_left <= '0;
`ifdef CHNL_RX_ALIGN_EN
      keep_left <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (CHNL_RX) begin
            cnt_left <= beats_req;
`ifdef CHNL_RX_ALIGN_EN
            keep_left <= keep_req;
`endif
            state <= (beats_req == '0) ? S_WAIT_LOW : S_RECV;
          end
        end
        S_RECV: begin
          if (accept) cnt_left <= cnt_left - 1'b1;
`ifdef CHNL_RX_ALIGN_EN
          if (push) keep_left <= keep_left - 1'b1;
`endif
          // An early drop of CHNL_RX abandons the rest. Beats that were already
          // buffered still drain downstream.
          if (!CHNL_RX)                          state <= S_IDLE;
          else if (accept && cnt_left == 32'd1) state <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          // Wait here so that a request held high is acknowledged only once.
          if (!CHNL_RX) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  fifo #(
    .WIDTH (C_PCI_DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .in_data  (CHNL_RX_DATA),
    .in_val   (push),
    .in_rdy   (fifo_in_rdy),
    .out_data (fifo_out_data),
    .out_val  (fifo_out_val),
    .out_rdy  (fifo_out_rdy)
  );

  repacker #(
    .IN  (C_PCI_DATA_WIDTH / GCD),
    .OUT (RX_WIDTH / GCD),
    .W   (GCD)
  ) u_repacker (
    .clk      (clk),
    .rst      (rst),
    .in_data  (fifo_out_data),
    .in_val   (fifo_out_val),
    .in_rdy   (fifo_out_rdy),
    .out_data (o_data),
    .out_val  (o_val),
    .out_rdy  (o_rdy)
  );

endmodule

// File: tb/tb_chnl_rx.sv
// tb/tb_chnl_rx.sv - scoreboard bench for chnl_rx with randomized host and sink

module tb_chnl_rx;

  localparam int PCI_W = 64;
  localparam int RX_W  = 32;
  localparam int WPB   = PCI_W / 32;
  localparam int ALIGN = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             o_val;
  logic             o_rdy;
  logic [RX_W-1:0]  o_data;
  logic             rx_busy;
  logic             CHNL_RX_CLK;
  logic             CHNL_RX;
  logic             CHNL_RX_ACK;
  logic             CHNL_RX_LAST;
  logic [31:0]      CHNL_RX_LEN;
  logic [30:0]      CHNL_RX_OFF;
  logic [PCI_W-1:0] CHNL_RX_DATA;
  logic             CHNL_RX_DATA_VALID;
  logic             CHNL_RX_DATA_REN;

  chnl_rx #(
    .C_PCI_DATA_WIDTH (PCI_W),
    .RX_WIDTH         (RX_W),
    .GCD              (32),
    .CHNL_ALIGN       (ALIGN)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .o_val              (o_val),
    .o_rdy              (o_rdy),
    .o_data             (o_data),
    .rx_busy            (rx_busy),
    .CHNL_RX_CLK        (CHNL_RX_CLK),
    .CHNL_RX            (CHNL_RX),
    .CHNL_RX_ACK        (CHNL_RX_ACK),
    .CHNL_RX_LAST       (CHNL_RX_LAST),
    .CHNL_RX_LEN        (CHNL_RX_LEN),
    .CHNL_RX_OFF        (CHNL_RX_OFF),
    .CHNL_RX_DATA       (CHNL_RX_DATA),
    .CHNL_RX_DATA_VALID (CHNL_RX_DATA_VALID),
    .CHNL_RX_DATA_REN   (CHNL_RX_DATA_REN)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          ack_cnt  = 0;
  int          rdy_mode = 1;
  int          stall_left = 0;
  bit          ren_low_seen;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name, input string why);
    n_checks++;
    $display("FAIL %s: %s", name, why);
  endtask

  // Output monitor: pops the scoreboard on every handshake and checks that stalled data stays stable.
  initial begin
    bit          held;
    logic [31:0] hd;
    held = 0;
    hd   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 0;
        continue;
      end
      if (held) begin
        chk("hold_val", o_val, 1);
        chk("hold_data", o_data, hd);
      end
      if (CHNL_RX_ACK) begin
        ack_cnt++;
        chk("ack_only_idle", rx_busy, 0);
      end
      if (o_val && o_rdy) begin
        if (exp_q.size() == 0) fail("extra_word", $sformatf("got %0h, expected no word", o_data));
        else chk("data", o_data, exp_q.pop_front());
      end
      held = o_val && !o_rdy;
      hd   = o_data;
    end
  end

  // Sink ready: optional initial stall, then constant or random.
  initial begin
    o_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
        o_rdy = 1'b0;
        stall_left--;
      end else begin
        case (rdy_mode)
          0:       o_rdy = 1'b0;
          1:       o_rdy = 1'b1;
          default: o_rdy = 1'($urandom_range(0, 1));
        endcase
      end
    end
  end

  // One host transaction. abort_kind: 0 = runs to completion, 1 = CHNL_RX drops
  // after abort_at beats, 2 = rst is pulsed after abort_at beats.
  task automatic txn(input int len, input int abort_at, input int abort_kind,
                     input int hold, input bit rand_valid);
    int          beats;
    int          kept;
    int          sent;
    int          waitc;
    int          ack0;
    logic [63:0] beat;
    beats = (len + WPB - 1) / WPB;
`ifdef CHNL_RX_ALIGN_EN
    kept = ((len / ALIGN) * ALIGN) / WPB;
`else
    kept = beats;
`endif
    ack0 = ack_cnt;
    ren_low_seen = 0;
    @(posedge clk);
    #1;
    CHNL_RX      = 1'b1;
    CHNL_RX_LEN  = 32'(len);
    CHNL_RX_OFF  = 31'($urandom);
    CHNL_RX_LAST = 1'b1;
    @(negedge clk);
    chk("ack_on_request", CHNL_RX_ACK, 1);
    sent  = 0;
    waitc = 0;
    while (sent < beats && sent != abort_at && waitc < 20000) begin
      @(posedge clk);
      #1;
      beat = {$urandom, $urandom};
      CHNL_RX_DATA       = beat;
      CHNL_RX_DATA_VALID = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      waitc++;
      if (!CHNL_RX_DATA_REN) ren_low_seen = 1;
      if (CHNL_RX_DATA_REN && CHNL_RX_DATA_VALID) begin
        if (sent < kept)
          for (int k = 0; k < WPB; k++) exp_q.push_back(beat[k*32 +: 32]);
        sent++;
      end
    end
    if (waitc >= 20000) fail("beat_timeout", $sformatf("%0d of %0d beats read", sent, beats));
    @(posedge clk);
    #1;
    CHNL_RX_DATA_VALID = 1'b0;
    if (abort_at < 0 || abort_at >= beats) begin
      @(negedge clk);
      chk("ren_after_last", CHNL_RX_DATA_REN, 0);
      chk("busy_wait_low", rx_busy, 1);
      repeat (hold) @(posedge clk);
      @(posedge clk);
      #1;
      CHNL_RX = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("idle_after_low", rx_busy, 0);
    end else if (abort_kind == 1) begin
      CHNL_RX = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("idle_after_drop", rx_busy, 0);
    end else begin
      rst = 1'b1;
      #1;
      chk("rst_o_val", o_val, 0);
      chk("rst_ren", CHNL_RX_DATA_REN, 0);
      chk("rst_busy", rx_busy, 0);
      exp_q.delete();
      CHNL_RX = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
    end
    chk("ack_once", ack_cnt - ack0, 1);
  endtask

  task automatic drain();
    int waitc;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 10000) begin
      @(negedge clk);
      waitc++;
    end
    repeat (8) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int a0;
    rst                = 1'b1;
    CHNL_RX            = 1'b0;
    CHNL_RX_LAST       = 1'b0;
    CHNL_RX_LEN        = '0;
    CHNL_RX_OFF        = '0;
    CHNL_RX_DATA       = '0;
    CHNL_RX_DATA_VALID = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_o_val", o_val, 0);
    chk("reset_ren", CHNL_RX_DATA_REN, 0);
    chk("reset_ack", CHNL_RX_ACK, 0);
    chk("reset_busy", rx_busy, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_busy", rx_busy, 0);
    chk("rx_clk_follows", CHNL_RX_CLK, clk);

    // Eight words, data valid every cycle, free-running sink.
    rdy_mode = 1;
    txn(8, -1, 0, 0, 0);
    drain();

    // Odd length: the pad word of the final beat is forwarded.
    txn(5, -1, 0, 0, 0);
    drain();

    // Long transaction against a stalled sink: the FIFO fills and REN backs off.
    stall_left = 300;
    txn(4096, -1, 0, 0, 0);
    chk("ren_backpressure", ren_low_seen, 1);
    drain();

    // Request held high for a while, then a short one: two acknowledges in total.
    a0 = ack_cnt;
    txn(8, -1, 0, 20, 0);
    txn(2, -1, 0, 0, 0);
    chk("ack_two_total", ack_cnt - a0, 2);
    drain();

    // Early drop after 2 of 4 beats, then a normal transaction.
    txn(8, 2, 1, 0, 0);
    drain();
    txn(6, -1, 0, 0, 0);
    drain();

    // Alignment case and zero length.
    txn(10, -1, 0, 0, 1);
    drain();
    txn(0, -1, 0, 3, 0);
    drain();

    // Randomized transactions against a random sink.
    rdy_mode = 2;
    for (int t = 0; t < 20; t++) begin
      int len;
      len = $urandom_range(0, 24);
      if ($urandom_range(0, 3) == 0 && len > 4)
        txn(len, int'($urandom_range(1, 2)), 1, 0, 1);
      else
        txn(len, -1, 0, int'($urandom_range(0, 4)), 1);
      if (t % 5 == 4) drain();
    end
    drain();

    // Reset in the middle of a transfer, then recovery.
    txn(40, 6, 2, 0, 0);
    drain();
    txn(12, -1, 0, 0, 1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/chnl_rx.md
Name: chnl_rx

Overview:
Buffered RIFFA/CHNL receiver, the host-to-FPGA counterpart of the channel transmitter. It accepts one RIFFA RX transaction at a time and stores incoming beats in a FIFO. It repacks them from C_PCI_DATA_WIDTH to RX_WIDTH and presents them on a valid/ready stream. That stream feeds the command/data logic that in turn drives the transmit channel.

Parameters:
C_PCI_DATA_WIDTH, 32, RIFFA data width in bits (≥32, multiple of 32)
RX_WIDTH, 32, output stream width in bits
GCD, 32, gcd(RX_WIDTH, C_PCI_DATA_WIDTH)
CHNL_ALIGN, 4, alignment unit in 32-bit words (used only with CHNL_RX_ALIGN_EN)

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
o_val  out  1  output data valid
o_rdy  in  1  downstream ready
o_data  out  RX_WIDTH  output data
rx_busy  out  1  high while a transaction is open (state ≠ S_IDLE)
CHNL_RX_CLK  out  1  equals clk
CHNL_RX  in  1  host transaction request
CHNL_RX_ACK  out  1  transaction acknowledge pulse
CHNL_RX_LAST  in  1  ignored
CHNL_RX_LEN  in  32  transaction length in 32-bit words
CHNL_RX_OFF  in  31  ignored
CHNL_RX_DATA  in  C_PCI_DATA_WIDTH  host data
CHNL_RX_DATA_VALID  in  1  host data valid
CHNL_RX_DATA_REN  out  1  data read enable

Behaviour:
- Reset values: state = S_IDLE; beat counters = 0; CHNL_RX_ACK = 0; CHNL_RX_DATA_REN = 0; FIFO and repacker empty, so o_val = 0.
- W = C_PCI_DATA_WIDTH/32 words per beat.
- Beat target: beats = (CHNL_RX_LEN + W − 1) / W, 32-bit unsigned, computed from the value sampled at acceptance.
- States: S_IDLE, S_RECV, S_WAIT_LOW.
- S_IDLE:
  - When CHNL_RX = 1: CHNL_RX_ACK = 1 combinationally for exactly this cycle, beat target and cnt_left are latched.
  - If beats = 0, next state is S_WAIT_LOW; otherwise S_RECV.
- S_RECV:
  - CHNL_RX_DATA_REN = fifo_in_rdy.
  - A beat is accepted when REN && CHNL_RX_DATA_VALID.
  - Each accepted beat decrements cnt_left. On the beat where cnt_left = 1, next state is S_WAIT_LOW.
  - If CHNL_RX falls before all beats arrive: go to S_IDLE immediately. Beats already accepted stay in the FIFO; nothing is flushed.
- S_WAIT_LOW:
  - REN = 0, ACK = 0.
  - Return to S_IDLE when CHNL_RX = 0. This guarantees exactly one ACK per transaction, even if CHNL_RX is held high.
- CHNL_RX_ACK is never asserted outside S_IDLE.
- A pad word in the final partial beat (LEN not a multiple of W) is forwarded as received.
- FIFO full: REN drops the same cycle. No beat is lost, because acceptance requires REN.
- Output side:
  - Standard valid/ready: data is held stable while o_val && !o_rdy.
  - Latency from accepted beat to o_val is fixed by fifo plus repacker (2 cycles minimum with o_rdy = 1).
- Simultaneous push and pop of the FIFO is permitted.
- rst mid-transaction: returns to S_IDLE and empties all buffers. The host transaction is abandoned.

Optional Feature:
CHNL_RX_ALIGN_EN
- Defined:
  - Kept beats = ((LEN / CHNL_ALIGN) * CHNL_ALIGN) / W, a whole number because CHNL_ALIGN ≥ W.
  - Beats beyond the kept count are still read (REN asserted regardless of FIFO space) but are not pushed.
  - Consequence: the output stream always carries whole CHNL_ALIGN groups.
- Undefined: every received beat is forwarded.

Decomposition:
- Shared package chnl_pkg:
  - State encoding S_IDLE/S_RECV/S_WAIT_LOW.
  - Helper constant function for words-per-beat.
- Reuse the existing fifo (WIDTH = C_PCI_DATA_WIDTH) and repacker (IN = C_PCI_DATA_WIDTH/GCD, OUT = RX_WIDTH/GCD, W = GCD).
- No new sub-module.

Test Plan:
1. C_PCI_DATA_WIDTH = 64, LEN = 8, VALID always high, o_rdy = 1 → one ACK pulse; 4 beats read; 8 words out in order; rx_busy drops once CHNL_RX is low.
2. LEN = 5, W = 2 → 3 beats read; the 6th (pad) word appears on output; state reaches S_WAIT_LOW after beat 3.
3. o_rdy = 0 with LEN = 4096 words → REN deasserts when the FIFO fills; raising o_rdy resumes transfer; all 4096 words delivered intact.
4. CHNL_RX held high 20 cycles after the final beat, then a second transaction of LEN = 2 → exactly 2 ACK pulses total.
5. CHNL_RX dropped after 2 of 4 beats → S_IDLE the next cycle; the 2 accepted beats are delivered; a new transaction is accepted normally.
6. CHNL_RX_ALIGN_EN, CHNL_ALIGN = 4, W = 2, LEN = 10 → 5 beats read, 8 words output; rst asserted mid-transfer → o_val = 0, REN = 0 the same cycle.
